countdown_bcd_99: RTL and testbench
===================================

# countdown_bcd_99

Two-digit BCD down counter (99 → 00) driven from the 50 MHz board clock through an internal prescaler. It complements the existing 0–9 up counter: it reads a preset from the switches, counts toward zero, and signals completion. Outputs feed the 7-segment decoders, and the `done` pulse feeds board LEDs or downstream control.

## Interface
Parameters:
- `DIV`, default 50_000_000: clock cycles per count tick (1 Hz at 50 MHz); legal range ≥ 2.
- `CW`, default 26: prescaler counter width; must satisfy 2^CW ≥ DIV.

Ports (one clock; reset is synchronous and active-low):
- `clock_50`  in  1  system clock, all logic on the rising edge.
- `reset_n`  in  1  synchronous active-low reset.
- `load`  in  1  level; while high, the count is loaded from `load_val` and the FSM goes to IDLE.
- `load_val`  in  8  BCD preset: [7:4] tens, [3:0] ones.
- `start`  in  1  single-cycle pulse; begins or resumes counting.
- `pause`  in  1  single-cycle pulse; freezes counting.
- `tens`  out  4  BCD tens digit.
- `ones`  out  4  BCD ones digit.
- `running`  out  1  high in RUN state.
- `done`  out  1  one-cycle pulse when the count reaches 00.

## Operation
FSM states: IDLE, RUN, PAUSE, DONE.
- Reset (reset_n=0 at an edge): state IDLE, tens=0, ones=0, prescaler=0, running=0, done=0. Reset mid-count aborts the count immediately; no done pulse.
- Input priority: reset > load > start > pause.
- load in any state: state IDLE, prescaler=0. Each digit is taken from `load_val`, except that a nibble > 9 is clamped to 9. `done` is held at 0.
- IDLE + start: if the count is 00, go to DONE. Otherwise go to RUN with prescaler=0.
- RUN: the prescaler increments every cycle. When prescaler == DIV-1, a tick occurs and the prescaler wraps to 0.
  - On each tick, the count decrements. ones=0 borrows: ones→9 and tens decrements.
  - A decrement that yields 00 moves the FSM to DONE.
- RUN + pause: go to PAUSE. The prescaler value is held, not cleared.
- PAUSE + start: go to RUN, resuming from the held prescaler value.
- DONE: the count stays at 00. start is ignored. Only load or reset leaves DONE.
- start in RUN and pause outside RUN: no effect.
- Simultaneous tick and pause in RUN: pause wins and no decrement occurs that cycle.
- Simultaneous tick and load: load wins.
- Arithmetic is per-digit BCD. The count never holds a non-BCD value and never wraps below 00.

## Timing
- All outputs are registered and update one cycle after the causing edge.
- Tick latency: the first decrement occurs DIV cycles after the edge that enters RUN. Later decrements occur every DIV cycles.
- `done` is high for exactly the one cycle after entering DONE. It coincides with the first cycle in which tens/ones read 00.
- IDLE + start at count 00: `done` is asserted on the next cycle.
- `running` = 1 exactly while state == RUN. It drops in the same cycle `done` rises.
- A full count from preset N (BCD value n) takes n·DIV cycles from start to done.

## Structure
- Shared package `counter_pkg`:
  - FSM state encoding (2-bit localparams: IDLE=0, RUN=1, PAUSE=2, DONE=3).
  - BCD constants BCD_MAX=4'd9 and BCD_ZERO=4'd0.
  - The clamp rule, written as a function `bcd_clamp`.
- Sub-module `bcd_digit_down`: one 4-bit BCD digit.
  - Inputs: `dec`, `load`, `d`.
  - Outputs: `q`, `borrow` (combinational, high when dec && q==0).
  - Instantiated twice; the ones `borrow` drives the tens `dec`.
- Top level holds the FSM and prescaler.

## Test plan
All scenarios use DIV=4.
- Reset: drive reset_n=0 for 2 cycles while load=1 and load_val=8'h57 → tens=0, ones=0, running=0, done=0.
- Basic count: load 8'h12, then start → count reads 11, 10, 09, … 01, 00 at 4-cycle spacing. `done` pulses once, 48 cycles after start, and running=0 afterward.
- Borrow: load 8'h20, then start → after 4 cycles the display reads 19.
- Clamp: load 8'hAF → display reads 99. Start with DIV=4 → done arrives 396 cycles later.
- Pause/resume: load 8'h05, start, pause 2 cycles into a tick period, hold 10 cycles, then start → the next decrement occurs 2 cycles after resume. Total elapsed time to done is 20 cycles plus the paused cycles.
- Edge events:
  - Start at 00 → done pulses on the next cycle.
  - Pause coincident with a tick → no decrement.
  - Load during RUN → IDLE with the new value and no done pulse.
  - reset_n=0 mid-count → 00, IDLE, no done pulse.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the board counter blocks: FSM state codes, BCD limits
// and the preset clamp rule.
package counter_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // A switch nibble above 9 is not a BCD digit; treat it as 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit that counts down 9..0 and wraps to 9 with a borrow.
module bcd_digit_down
  import counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       borrow
);

  logic [3:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= BCD_ZERO;
    end else if (load) begin
      r_q <= d;
    end else if (dec) begin
      r_q <= (r_q == BCD_ZERO) ? BCD_MAX : r_q - 4'd1;
    end
  end

  assign q      = r_q;
  assign borrow = dec && (r_q == BCD_ZERO);

endmodule

// File: rtl/countdown_bcd_99.sv
// Two-digit BCD down counter (99..00) with prescaler, pause/resume and a
// one-cycle done pulse on reaching 00.
module countdown_bcd_99
  import counter_pkg::*;
#(
  parameter int unsigned DIV = 50_000_000,
  parameter int unsigned CW  = 26
) (
  input  logic       clock_50,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done
);

  localparam logic [CW-1:0] PrescLast = CW'(DIV - 1);

  logic [1:0]    r_state, w_state_d;
  logic [CW-1:0] r_presc, w_presc_d;
  logic          r_done, w_done_d;
  logic          w_tick, w_dec, w_at_one;
  logic          w_borrow_ones, w_borrow_tens;
  logic [3:0]    w_tens, w_ones;

  assign w_tick   = (r_presc == PrescLast);
  assign w_at_one = (w_tens == BCD_ZERO) && (w_ones == 4'd1);

  always_comb begin
    w_state_d = r_state;
    w_presc_d = r_presc;
    w_done_d  = 1'b0;
    w_dec     = 1'b0;
    if (load) begin
      w_state_d = StIdle;
      w_presc_d = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            if (w_tens == BCD_ZERO && w_ones == BCD_ZERO) begin
              w_state_d = StDone;
              w_done_d  = 1'b1;
            end else begin
              w_state_d = StRun;
              w_presc_d = '0;
            end
          end
        end
        StRun: begin
          // Pause beats a coincident tick; the prescaler is frozen as-is.
          if (pause) begin
            w_state_d = StPause;
          end else if (w_tick) begin
            w_presc_d = '0;
            w_dec     = 1'b1;
            if (w_at_one) begin
              w_state_d = StDone;
              w_done_d  = 1'b1;
            end
          end else begin
            w_presc_d = r_presc + CW'(1);
          end
        end
        StPause: begin
          if (start) w_state_d = StRun;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_presc <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_presc <= w_presc_d;
      r_done  <= w_done_d;
    end
  end

  bcd_digit_down u_ones (
    .clk    (clock_50),
    .rst_n  (reset_n),
    .dec    (w_dec),
    .load   (load),
    .d      (bcd_clamp(load_val[3:0])),
    .q      (w_ones),
    .borrow (w_borrow_ones)
  );

  bcd_digit_down u_tens (
    .clk    (clock_50),
    .rst_n  (reset_n),
    .dec    (w_borrow_ones),
    .load   (load),
    .d      (bcd_clamp(load_val[7:4])),
    .q      (w_tens),
    .borrow (w_borrow_tens)
  );

  // The FSM stops at 01 -> 00, so the tens digit must never be asked to borrow.
  always_ff @(posedge clock_50) begin
    if (reset_n) assert (!w_borrow_tens);
  end

  assign tens    = w_tens;
  assign ones    = w_ones;
  assign running = (r_state == StRun);
  assign done    = r_done;

endmodule

// File: tb/tb_countdown_bcd_99.sv
// Bench for countdown_bcd_99 at DIV=4: preset table, directed corner sequences
// and randomized traffic against a decimal reference model.
module tb_countdown_bcd_99;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n, load, start, pause;
  logic [7:0] load_val;
  logic [3:0] tens, ones;
  logic       running, done;

  always #5 clk = ~clk;

  countdown_bcd_99 #(
    .DIV (4),
    .CW  (3)
  ) dut (
    .clock_50 (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .tens     (tens),
    .ones     (ones),
    .running  (running),
    .done     (done)
  );

  int total = 0;
  int bad   = 0;
  int edges = 0;

  // Reference model: count kept as a plain decimal number.
  typedef enum int {MIdle, MCounting, MHeld, MFinished} mode_t;
  mode_t m_mode  = MIdle;
  int    m_n     = 0;
  int    m_phase = 0;
  bit    m_done  = 1'b0;

  function automatic int clampd(input logic [3:0] v);
    return (v > 4'd9) ? 9 : int'(v);
  endfunction

  function automatic void model_step();
    if (!reset_n) begin
      m_n = 0; m_mode = MIdle; m_phase = 0; m_done = 1'b0;
    end else if (load) begin
      m_n = clampd(load_val[7:4]) * 10 + clampd(load_val[3:0]);
      m_mode = MIdle; m_phase = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_mode)
        MIdle: if (start) begin
          if (m_n == 0) begin m_mode = MFinished; m_done = 1'b1; end
          else begin m_mode = MCounting; m_phase = 0; end
        end
        MCounting: begin
          if (pause) m_mode = MHeld;
          else if (m_phase == DIV - 1) begin
            m_phase = 0;
            m_n = m_n - 1;
            if (m_n == 0) begin m_mode = MFinished; m_done = 1'b1; end
          end else m_phase = m_phase + 1;
        end
        MHeld: if (start) m_mode = MCounting;
        default: ;
      endcase
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; model advances on the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    edges++;
    @(negedge clk);
    chk("model.tens", 32'(tens), 32'(m_n / 10));
    chk("model.ones", 32'(ones), 32'(m_n % 10));
    chk("model.running", 32'(running), 32'(m_mode == MCounting));
    chk("model.done", 32'(done), 32'(m_done));
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1) begin
      if (n >= limit) begin
        total++; bad++;
        $display("FAIL wait_done: got no done within %0d cycles, expected a pulse", n);
        return;
      end
      cyc();
      n++;
    end
  endtask

  typedef struct {
    logic [7:0] lv;
    logic [3:0] t;
    logic [3:0] o;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, e0, seen;

    tbl[0] = '{8'h57, 4'd5, 4'd7};
    tbl[1] = '{8'hAF, 4'd9, 4'd9};
    tbl[2] = '{8'h12, 4'd1, 4'd2};
    tbl[3] = '{8'h20, 4'd2, 4'd0};
    tbl[4] = '{8'h09, 4'd0, 4'd9};
    tbl[5] = '{8'h90, 4'd9, 4'd0};
    tbl[6] = '{8'hA0, 4'd9, 4'd0};
    tbl[7] = '{8'h0B, 4'd0, 4'd9};
    tbl[8] = '{8'hFF, 4'd9, 4'd9};
    tbl[9] = '{8'h00, 4'd0, 4'd0};

    reset_n = 1'b0; load = 1'b1; load_val = 8'h57; start = 1'b0; pause = 1'b0;
    @(negedge clk);
    cyc();
    cyc();
    chk("reset.tens", 32'(tens), 0);
    chk("reset.ones", 32'(ones), 0);
    chk("reset.running", 32'(running), 0);
    chk("reset.done", 32'(done), 0);
    reset_n = 1'b1; load = 1'b0;
    cyc();

    for (int i = 0; i < 10; i++) begin
      do_load(tbl[i].lv);
      chk("table.tens", 32'(tens), 32'(tbl[i].t));
      chk("table.ones", 32'(ones), 32'(tbl[i].o));
    end

    // Basic count from 12.
    do_load(8'h12);
    pulse_start();
    chk("basic.running", 32'(running), 1);
    repeat (4) cyc();
    chk("basic.first_tens", 32'(tens), 1);
    chk("basic.first_ones", 32'(ones), 1);
    wait_done(200, n);
    chk("basic.latency", 32'(n + 4), 48);
    chk("basic.zero", 32'({tens, ones}), 0);
    chk("basic.running_after", 32'(running), 0);
    cyc();
    chk("basic.done_one_cycle", 32'(done), 0);

    // Borrow across the tens digit.
    do_load(8'h20);
    pulse_start();
    repeat (4) cyc();
    chk("borrow.tens", 32'(tens), 1);
    chk("borrow.ones", 32'(ones), 9);

    // Clamped preset counts a full 99.
    do_load(8'hAF);
    chk("clamp.value", 32'({tens, ones}), 32'h99);
    pulse_start();
    wait_done(500, n);
    chk("clamp.latency", 32'(n), 396);

    // Pause two cycles into a tick period, hold, resume.
    do_load(8'h05);
    pulse_start();
    e0 = edges;
    cyc();
    cyc();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk("pause.running", 32'(running), 0);
    repeat (10) cyc();
    chk("pause.held_ones", 32'(ones), 5);
    pulse_start();
    chk("pause.resumed", 32'(running), 1);
    cyc();
    chk("pause.resume_plus1", 32'(ones), 5);
    cyc();
    chk("pause.resume_plus2", 32'(ones), 4);
    wait_done(200, n);
    chk("pause.total", 32'(edges - e0), 32);

    // Start at 00: done on the next cycle; start ignored afterwards.
    do_load(8'h00);
    pulse_start();
    chk("zero.done", 32'(done), 1);
    chk("zero.running", 32'(running), 0);
    cyc();
    chk("zero.done_drop", 32'(done), 0);
    pulse_start();
    chk("zero.start_ignored", 32'(done), 0);

    // Pause coincident with a tick.
    do_load(8'h03);
    pulse_start();
    repeat (3) cyc();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk("pausetick.no_dec", 32'(ones), 3);
    chk("pausetick.running", 32'(running), 0);
    pulse_start();
    chk("pausetick.resume_hold", 32'(ones), 3);
    cyc();
    chk("pausetick.dec_next", 32'(ones), 2);

    // Load during RUN.
    do_load(8'h12);
    pulse_start();
    repeat (6) cyc();
    do_load(8'h45);
    chk("runload.value", 32'({tens, ones}), 32'h45);
    chk("runload.running", 32'(running), 0);
    seen = 0;
    repeat (20) begin cyc(); if (done === 1'b1) seen++; end
    chk("runload.no_done", 32'(seen), 0);
    chk("runload.held", 32'({tens, ones}), 32'h45);

    // Reset mid-count.
    do_load(8'h30);
    pulse_start();
    repeat (6) cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("midreset.value", 32'({tens, ones}), 0);
    chk("midreset.running", 32'(running), 0);
    chk("midreset.done", 32'(done), 0);
    seen = 0;
    repeat (10) begin cyc(); if (done === 1'b1) seen++; end
    chk("midreset.no_done", 32'(seen), 0);

    // Randomized traffic; mostly small presets so runs reach 00.
    for (int i = 0; i < 3000; i++) begin
      reset_n  = ($urandom_range(0, 299) != 0);
      load     = ($urandom_range(0, 39) == 0);
      start    = ($urandom_range(0, 5) == 0);
      pause    = ($urandom_range(0, 9) == 0);
      load_val = ($urandom_range(0, 3) != 0) ? {4'h0, 4'($urandom_range(0, 15))}
                                             : 8'($urandom_range(0, 255));
      cyc();
    end
    reset_n = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
